pagerank_graph_loader: RTL

Producer side of the PageRank engine's graph interface: accepts a serial stream of directed edges over a valid/ready handshake, builds the flat N×N adjacency vector and the per-node out-link weight vector, and presents them to the rank engine with a valid/ack handshake. Weights are 1/out-degree in the engine's 16-bit fixed point, computed by an on-block sequential divider.

---
 rtl/pagerank_graph_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pagerank_graph_loader.sv
// Edge-stream loader for the PageRank engine: builds the N*N adjacency vector and 1/out-degree weights.
// Optional macro PR_SELF_LOOP_DROP_EN: accept src==dst beats but do not store them.
module pagerank_graph_loader #(
  parameter int N     = 16,
  parameter int WIDTH = 16,
  parameter int IDW   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               edge_valid,
  output logic               edge_ready,
  input  logic [IDW-1:0]     edge_src,
  input  logic [IDW-1:0]     edge_dst,
  input  logic               edge_last,
  output logic [N*N-1:0]     adjacency,
  output logic [N*WIDTH-1:0] weights,
  output logic               graph_valid,
  input  logic               graph_ack,
  output logic               self_loop_seen
);
  localparam int ITW = $clog2(WIDTH + 1);
  localparam logic [ITW-1:0] LAST_ITER = ITW'(WIDTH);
  localparam logic [ITW-1:0] ITER_ONE  = {{(ITW-1){1'b0}}, 1'b1};
  localparam logic [IDW:0]   NODE_END  = (IDW+1)'(N);
  localparam logic [IDW:0]   ONE_IDX   = {{IDW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {LOAD = 2'd0, WEIGH = 2'd1, HOLD = 2'd2} state_t;

  state_t             state_r, next_state_s;
  logic               edge_ready_r, graph_valid_r, self_loop_r;
  logic [N*N-1:0]     adjacency_r;
  logic [N*WIDTH-1:0] weights_r;
  logic [IDW:0]       outdeg_r [N];
  logic [IDW:0]       node_r;
  logic [ITW-1:0]     iter_r;
  logic [IDW+1:0]     rem_r;
  logic [WIDTH:0]     quot_r;

  logic               accept_s, dup_s, store_s, clear_s, div_active_s, last_iter_s, qbit_s;
  logic [2*IDW-1:0]   idx_s;
  logic [IDW:0]       div_s;
  logic [IDW+1:0]     rem_shift_s, rem_next_s;
  logic [WIDTH:0]     quot_next_s;
  logic [WIDTH-1:0]   weight_s;

  // N is a power of two, so {dst,src} equals dst*N+src
  assign idx_s    = {edge_dst, edge_src};
  assign accept_s = edge_valid && edge_ready_r && (state_r == LOAD);
  assign dup_s    = adjacency_r[idx_s];
  assign clear_s  = (state_r == HOLD) && graph_ack;
`ifdef PR_SELF_LOOP_DROP_EN
  assign store_s  = accept_s && !dup_s && (edge_src != edge_dst);
`else
  assign store_s  = accept_s && !dup_s;
`endif

  assign div_active_s = (state_r == WEIGH) && (node_r != NODE_END);
  assign last_iter_s  = (iter_r == LAST_ITER);
  assign div_s        = outdeg_r[node_r[IDW-1:0]];

  // One restoring-divide step of 2^WIDTH by the current node's out-degree
  always_comb begin
    rem_shift_s = {(IDW+2){1'b0}};
    rem_next_s  = {(IDW+2){1'b0}};
    qbit_s      = 1'b0;
    quot_next_s = {(WIDTH+1){1'b0}};
    weight_s    = {WIDTH{1'b0}};
    if (iter_r == {ITW{1'b0}}) begin
      rem_shift_s = {{(IDW+1){1'b0}}, 1'b1};
    end else begin
      rem_shift_s = rem_r << 1;
    end
    if (rem_shift_s >= {1'b0, div_s}) begin
      rem_next_s = rem_shift_s - {1'b0, div_s};
      qbit_s     = 1'b1;
    end else begin
      rem_next_s = rem_shift_s;
      qbit_s     = 1'b0;
    end
    if (iter_r == {ITW{1'b0}}) begin
      quot_next_s = {{WIDTH{1'b0}}, qbit_s};
    end else begin
      quot_next_s = (quot_r << 1) | {{WIDTH{1'b0}}, qbit_s};
    end
    if (div_s == {(IDW+1){1'b0}}) begin
      weight_s = {WIDTH{1'b0}};
    end else if (quot_next_s[WIDTH]) begin
      weight_s = {WIDTH{1'b1}};
    end else begin
      weight_s = quot_next_s[WIDTH-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LOAD: begin
        if (accept_s && edge_last) next_state_s = WEIGH;
        else                       next_state_s = LOAD;
      end
      WEIGH: begin
        if (node_r == NODE_END) next_state_s = HOLD;
        else                    next_state_s = WEIGH;
      end
      HOLD: begin
        if (graph_ack) next_state_s = LOAD;
        else           next_state_s = HOLD;
      end
      default: next_state_s = LOAD;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= LOAD;
      edge_ready_r  <= 1'b0;
      graph_valid_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      edge_ready_r  <= (next_state_s == LOAD);
      graph_valid_r <= (next_state_s == HOLD);
    end
  end

  // Graph storage and divider datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adjacency_r <= {(N*N){1'b0}};
      weights_r   <= {(N*WIDTH){1'b0}};
      self_loop_r <= 1'b0;
      node_r      <= {(IDW+1){1'b0}};
      iter_r      <= {ITW{1'b0}};
      rem_r       <= {(IDW+2){1'b0}};
      quot_r      <= {(WIDTH+1){1'b0}};
      for (int i = 0; i < N; i++) outdeg_r[i] <= {(IDW+1){1'b0}};
    end else if (clear_s) begin
      adjacency_r <= {(N*N){1'b0}};
      weights_r   <= {(N*WIDTH){1'b0}};
      self_loop_r <= 1'b0;
      node_r      <= {(IDW+1){1'b0}};
      iter_r      <= {ITW{1'b0}};
      rem_r       <= {(IDW+2){1'b0}};
      quot_r      <= {(WIDTH+1){1'b0}};
      for (int i = 0; i < N; i++) outdeg_r[i] <= {(IDW+1){1'b0}};
    end else begin
      if (accept_s && (edge_src == edge_dst)) self_loop_r <= 1'b1;
      if (store_s) begin
        adjacency_r[idx_s] <= 1'b1;
        outdeg_r[edge_src] <= outdeg_r[edge_src] + ONE_IDX;
      end
      if (div_active_s) begin
        rem_r  <= rem_next_s;
        quot_r <= quot_next_s;
        if (last_iter_s) begin
          weights_r[node_r[IDW-1:0]*WIDTH +: WIDTH] <= weight_s;
          node_r <= node_r + ONE_IDX;
          iter_r <= {ITW{1'b0}};
        end else begin
          iter_r <= iter_r + ITER_ONE;
        end
      end
    end
  end

  assign edge_ready     = edge_ready_r;
  assign graph_valid    = graph_valid_r;
  assign adjacency      = adjacency_r;
  assign weights        = weights_r;
  assign self_loop_seen = self_loop_r;
endmodule
